si_add: RTL and testbench
=========================

Name: si_add

Overview:
- Registered signed two's-complement adder used by the neural-network datapath for neuron accumulation and bias addition.
- Adds A and B, saturates the result to the signed range (or wraps, per parameter), and flags overflow.
- One-cycle latency with a valid strobe; sits between the multiplier stage and the activation stage.

Parameters:
- WIDTH, 8, operand and result width in bits; two's complement; legal range 2..32.
- SATURATE, 1, 1 = clamp on overflow; 0 = modulo-2^WIDTH wrap.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  A and B are sampled on this clock edge.
- A  input  WIDTH  signed operand.
- B  input  WIDTH  signed operand.
- out_valid  output  1  A_ADD_B, ovf and ovf_neg are valid this cycle.
- A_ADD_B  output  WIDTH  signed sum (saturated or wrapped).
- ovf  output  1  true signed sum fell outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- ovf_neg  output  1  direction of overflow: 1 = negative, 0 = positive; 0 when ovf=0.

Behaviour:
- Reset (rst_n low, asynchronous, regardless of clk): out_valid=0, A_ADD_B=0, ovf=0, ovf_neg=0. All outputs hold these values until the first accepted input after release.
- Internal sum:
  - Sign-extend A and B to WIDTH+1 bits and add; this sum is exact.
  - ovf = (sum[WIDTH] != sum[WIDTH-1]), equivalently A and B have the same sign and the truncated result has the opposite sign.
  - ovf_neg = ovf & A[WIDTH-1].
- Result selection:
  - SATURATE=1: positive overflow gives MAX = 2^(WIDTH-1)-1; negative overflow gives MIN = -2^(WIDTH-1); otherwise sum[WIDTH-1:0].
  - SATURATE=0: always sum[WIDTH-1:0]. The ovf and ovf_neg flags are still reported.
- Timing:
  - On a rising clk edge with in_valid=1: register the result and flags, and set out_valid=1 for exactly one cycle. Latency is 1 cycle.
  - in_valid=0: out_valid=0 next cycle; A_ADD_B, ovf and ovf_neg hold their last values.
- Back-to-back in_valid gives full throughput, one result per cycle, with no stall or backpressure.
- Reset asserted mid-operation: any pending result is discarded and all outputs go to reset values immediately.
- Boundaries:
  - MAX+0 = MAX, ovf=0.
  - MIN+MIN saturates to MIN with ovf=1, ovf_neg=1.
  - MAX+MIN = -1, ovf=0.
  - Adding operands of opposite sign never overflows.
- No X propagation from A or B while in_valid=0; unused operand values must not affect any output.

Decomposition:
- Package si_add_pkg:
  - default width constant (8);
  - functions/constants for signed MAX and MIN given WIDTH;
  - an overflow-direction enum {OVF_NONE, OVF_POS, OVF_NEG} for internal use.
- Sub-module si_sat (combinational):
  - inputs: WIDTH+1-bit sum;
  - outputs: WIDTH-bit clamped value, ovf, ovf_neg;
  - instantiated once; bypassed when SATURATE=0.
- The top level holds only the adder, output registers and valid pipeline.

Test Plan:
- Reset, basic sums and pipelining: rst_n=0 then 1; in_valid=1 each cycle with A=3,B=5 then A=4,B=2. Require 8 then 6 one cycle after each, out_valid=1 both cycles, ovf=0.
- Positive overflow: A=125, B=10.
  - SATURATE=1: require A_ADD_B=127, ovf=1, ovf_neg=0.
  - SATURATE=0: require A_ADD_B=-121 (0x87), ovf=1, ovf_neg=0.
- Mixed signs:
  - A=13, B=-1 -> 12;
  - A=-1, B=4 -> 3;
  - A=-1, B=-2 -> -3;
  - A=1, B=-2 -> -1.
  - ovf=0 for all four.
- Negative overflow and extremes:
  - A=-128, B=-1 -> -128, ovf=1, ovf_neg=1 (SATURATE=1);
  - A=-128, B=-128 -> -128;
  - A=127, B=-128 -> -1, ovf=0.
- Valid and hold: in_valid=0 for 3 cycles after A=3,B=5 while A and B toggle randomly. Require out_valid=0 and A_ADD_B held at 8.
- Async reset mid-stream: assert rst_n low between clock edges during a burst. Require outputs to go to 0 immediately without a clock edge; the first result after release appears one cycle after the next in_valid.

Source files
------------

// File: rtl/si_add_pkg.sv
// Shared constants and helpers for the signed saturating adder.
package si_add_pkg;

    parameter int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        OVF_NONE = 2'd0,
        OVF_POS  = 2'd1,
        OVF_NEG  = 2'd2
    } ovf_dir_e;

    // Bit patterns of the signed extremes, valid in the low w bits.
    function automatic logic [31:0] sat_max(input int w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

    function automatic logic [31:0] sat_min(input int w);
        return 32'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/si_sat.sv
// Clamps an exact WIDTH+1-bit signed sum to WIDTH bits and reports overflow.
module si_sat
    import si_add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH:0]   sum,
    output logic [WIDTH-1:0] sat,
    output logic             ovf,
    output logic             ovf_neg
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] MINV = WIDTH'(sat_min(WIDTH));

    ovf_dir_e dir;

    // On overflow the extra sign bit carries the true direction.
    always_comb begin
        dir = OVF_NONE;
        if (sum[WIDTH] != sum[WIDTH-1]) begin
            dir = sum[WIDTH] ? OVF_NEG : OVF_POS;
        end
    end

    always_comb begin
        sat     = sum[WIDTH-1:0];
        ovf     = 1'b0;
        ovf_neg = 1'b0;
        unique case (dir)
            OVF_POS: begin
                sat = MAXV;
                ovf = 1'b1;
            end
            OVF_NEG: begin
                sat     = MINV;
                ovf     = 1'b1;
                ovf_neg = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/si_add.sv
// Registered signed adder with optional saturation and overflow flags.
module si_add
    import si_add_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    output logic [WIDTH-1:0] A_ADD_B,
    output logic             ovf,
    output logic             ovf_neg
);

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] sat;
    logic [WIDTH-1:0] result;
    logic             sat_ovf;
    logic             sat_ovf_neg;

    assign sum = {A[WIDTH-1], A} + {B[WIDTH-1], B};

    si_sat #(
        .WIDTH(WIDTH)
    ) u_sat (
        .sum    (sum),
        .sat    (sat),
        .ovf    (sat_ovf),
        .ovf_neg(sat_ovf_neg)
    );

    assign result = SATURATE ? sat : sum[WIDTH-1:0];

    // Data registers only load on accepted inputs, so idle operands never leak.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            A_ADD_B   <= '0;
            ovf       <= 1'b0;
            ovf_neg   <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                A_ADD_B <= result;
                ovf     <= sat_ovf;
                ovf_neg <= sat_ovf_neg;
            end
        end
    end

endmodule

// File: tb/tb_si_add.sv
// Self-checking bench for si_add, saturating and wrapping variants side by side.
module tb_si_add;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] A = '0;
    logic [7:0] B = '0;

    logic       s_valid, w_valid;
    logic [7:0] s_sum, w_sum;
    logic       s_ovf, w_ovf, s_neg, w_neg;

    int checks = 0;
    int errors = 0;

    // Reference state for both variants.
    logic       m_valid;
    logic [7:0] m_s_sum, m_w_sum;
    logic       m_ovf, m_neg;

    always #5 clk = ~clk;

    si_add #(.WIDTH(8), .SATURATE(1'b1)) dut_sat (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .A        (A),
        .B        (B),
        .out_valid(s_valid),
        .A_ADD_B  (s_sum),
        .ovf      (s_ovf),
        .ovf_neg  (s_neg)
    );

    si_add #(.WIDTH(8), .SATURATE(1'b0)) dut_wrap (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .A        (A),
        .B        (B),
        .out_valid(w_valid),
        .A_ADD_B  (w_sum),
        .ovf      (w_ovf),
        .ovf_neg  (w_neg)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_s_sum = '0;
        m_w_sum = '0;
        m_ovf   = 1'b0;
        m_neg   = 1'b0;
    endtask

    // True integer sum, then clamp or wrap.
    task automatic model_accept(input logic [7:0] a, input logic [7:0] b);
        int s;
        s = int'($signed(a)) + int'($signed(b));
        m_ovf = (s > 127) || (s < -128);
        m_neg = (s < -128);
        m_w_sum = 8'(s);
        if (s > 127) m_s_sum = 8'd127;
        else if (s < -128) m_s_sum = 8'h80;
        else m_s_sum = 8'(s);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".sat.valid"}, 32'(s_valid), 32'(m_valid));
        chk({tag, ".sat.sum"}, 32'(s_sum), 32'(m_s_sum));
        chk({tag, ".sat.ovf"}, 32'(s_ovf), 32'(m_ovf));
        chk({tag, ".sat.neg"}, 32'(s_neg), 32'(m_neg));
        chk({tag, ".wrap.valid"}, 32'(w_valid), 32'(m_valid));
        chk({tag, ".wrap.sum"}, 32'(w_sum), 32'(m_w_sum));
        chk({tag, ".wrap.ovf"}, 32'(w_ovf), 32'(m_ovf));
        chk({tag, ".wrap.neg"}, 32'(w_neg), 32'(m_neg));
    endtask

    task automatic step(input string tag, input logic v, input logic [7:0] a, input logic [7:0] b);
        in_valid = v;
        A = a;
        B = b;
        @(posedge clk);
        m_valid = v;
        if (v) model_accept(a, b);
        #1;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        #12;
        check_all("reset");
        rst_n = 1'b1;
        @(negedge clk);

        step("add3_5", 1'b1, 8'd3, 8'd5);
        chk("add3_5.lit", 32'(s_sum), 32'd8);
        step("add4_2", 1'b1, 8'd4, 8'd2);
        chk("add4_2.lit", 32'(s_sum), 32'd6);

        step("pos_ovf", 1'b1, 8'd125, 8'd10);
        chk("pos_ovf.sat", 32'(s_sum), 32'd127);
        chk("pos_ovf.wrap", 32'(w_sum), 32'h87);

        step("mix13_m1", 1'b1, 8'd13, 8'hFF);
        chk("mix13_m1.lit", 32'(s_sum), 32'd12);
        step("mixm1_4", 1'b1, 8'hFF, 8'd4);
        step("mixm1_m2", 1'b1, 8'hFF, 8'hFE);
        chk("mixm1_m2.lit", 32'(s_sum), 32'hFD);
        step("mix1_m2", 1'b1, 8'd1, 8'hFE);

        step("neg_ovf", 1'b1, 8'h80, 8'hFF);
        chk("neg_ovf.neg", 32'(s_neg), 32'd1);
        step("min_min", 1'b1, 8'h80, 8'h80);
        chk("min_min.sat", 32'(s_sum), 32'h80);
        step("max_min", 1'b1, 8'd127, 8'h80);
        chk("max_min.lit", 32'(s_sum), 32'hFF);
        step("max_0", 1'b1, 8'd127, 8'd0);

        step("hold_ld", 1'b1, 8'd3, 8'd5);
        for (int i = 0; i < 3; i++) begin
            step("hold", 1'b0, 8'($urandom), 8'($urandom));
            chk("hold.lit", 32'(s_sum), 32'd8);
        end
        step("hold_x", 1'b0, 8'bx, 8'bx);

        for (int i = 0; i < 60; i++) begin
            step("rand", 1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom));
        end

        step("burst0", 1'b1, 8'd100, 8'd100);
        in_valid = 1'b1;
        A = 8'd7;
        B = 8'd9;
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        #2;
        rst_n = 1'b1;
        step("post_rst_idle", 1'b0, 8'd1, 8'd1);
        step("post_rst_add", 1'b1, 8'd3, 8'd5);
        chk("post_rst.lit", 32'(s_sum), 32'd8);
        step("post_rst_drain", 1'b0, 8'd0, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
